// File: rtl/joystick_adc_scheduler.sv
// Joystick ADC scheduler: time-shares one ADC between the X and Y axes,
// runs a periodic X-then-Y scan round with a start/done handshake and
// commits both axis values atomically. A hung conversion aborts the round.
module joystick_adc_scheduler #(
  parameter int unsigned SCAN_PERIOD    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [3:0]  CH_X           = 4'd6,
  parameter logic [3:0]  CH_Y           = 4'd7,
  parameter logic [9:0]  CENTER_VAL     = 10'd512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       adc_start,
  output logic [3:0] adc_ch,
  input  logic       adc_done,
  input  logic [9:0] adc_data,
  output logic [9:0] x_axis_out,
  output logic [9:0] y_axis_out,
  output logic       sample_valid,
  output logic       timeout_err
);

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned PER_W  = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START_X = 3'd1,
    S_WAIT_X  = 3'd2,
    S_START_Y = 3'd3,
    S_WAIT_Y  = 3'd4
  } state_t;

  state_t             state_q,  state_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [TO_W-1:0]    wait_q,   wait_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic [DATA_W-1:0]  x_q,      x_d;
  logic [DATA_W-1:0]  y_q,      y_d;
  logic [CH_W-1:0]    ch_q,     ch_d;
  logic               start_q,  start_d;
  logic               valid_q,  valid_d;
  logic               terr_q,   terr_d;

  // State and registered outputs; adc_start is set on entry to a start state
  // so that it is high for exactly the cycle the FSM sits in S_START_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      wait_q   <= '0;
      shadow_q <= CENTER_VAL;
      x_q      <= CENTER_VAL;
      y_q      <= CENTER_VAL;
      ch_q     <= CH_X;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ch_q     <= ch_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  // Next-state and next-output decode for the scan round.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    x_d      = x_q;
    y_d      = y_q;
    ch_d     = ch_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    terr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Period counter only advances on enabled cycles and holds otherwise.
        if (enable) begin
          if (period_q == PER_LAST) begin
            period_d = '0;
            state_d  = S_START_X;
            start_d  = 1'b1;
            ch_d     = CH_X;
          end else begin
            period_d = period_q + PER_W'(1);
          end
        end
      end

      S_START_X: begin
        wait_d  = '0;
        state_d = S_WAIT_X;
      end

      S_WAIT_X: begin
        // A done strobe on the last wait cycle still counts as success.
        if (adc_done) begin
          shadow_d = adc_data;
          state_d  = S_START_Y;
          start_d  = 1'b1;
          ch_d     = CH_Y;
        end else if (wait_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end

      S_START_Y: begin
        wait_d  = '0;
        state_d = S_WAIT_Y;
      end

      S_WAIT_Y: begin
        // Both axes commit together; an aborted round leaves them untouched.
        if (adc_done) begin
          x_d     = shadow_q;
          y_d     = adc_data;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (wait_q == TO_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign adc_start    = start_q;
  assign adc_ch       = ch_q;
  assign x_axis_out   = x_q;
  assign y_axis_out   = y_q;
  assign sample_valid = valid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_joystick_adc_scheduler.sv
// Scoreboard bench for joystick_adc_scheduler: stimulus pushes expected
// events (start/commit/timeout) and a negedge monitor pops and compares them.
module tb_joystick_adc_scheduler;

  localparam int unsigned SCAN_PERIOD = 4;
  localparam int unsigned TIMEOUT     = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       adc_start;
  logic [3:0] adc_ch;
  logic       adc_done;
  logic [9:0] adc_data;
  logic [9:0] x_axis_out;
  logic [9:0] y_axis_out;
  logic       sample_valid;
  logic       timeout_err;

  joystick_adc_scheduler #(
    .SCAN_PERIOD    (SCAN_PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CH_X           (4'd6),
    .CH_Y           (4'd7),
    .CENTER_VAL     (10'd512)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_start    (adc_start),
    .adc_ch       (adc_ch),
    .adc_done     (adc_done),
    .adc_data     (adc_data),
    .x_axis_out   (x_axis_out),
    .y_axis_out   (y_axis_out),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int { EV_START = 0, EV_VALID = 1, EV_TERR = 2 } ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [9:0] a;    // channel for START, x for VALID
    logic [9:0] b;    // y for VALID
    int         dly;  // cycles since previous event, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  last_evt_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t kind, input logic [9:0] a, input logic [9:0] b, input int dly);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic handle(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == e.kind) begin
        if (kind == EV_START) check("adc_ch", 32'(adc_ch), 32'(e.a));
        if (kind == EV_VALID) begin
          check("x_axis_commit", 32'(x_axis_out), 32'(e.a));
          check("y_axis_commit", 32'(y_axis_out), 32'(e.b));
        end
        if (e.dly >= 0) check("event_spacing", 32'(cyc - last_evt_cyc), 32'(e.dly));
      end
    end
    last_evt_cyc = cyc;
  endtask

  // Monitor: pops expectations on every output pulse, checks atomic commit.
  logic [9:0] x_prev = 10'd0;
  logic [9:0] y_prev = 10'd0;
  logic       rst_prev = 1'b1;
  always @(negedge clk) begin
    if (!rst && !rst_prev) begin
      if ((x_axis_out !== x_prev || y_axis_out !== y_prev) && !sample_valid)
        check("atomic_axis_update", 32'(sample_valid), 32'd1);
    end
    if (adc_start)    handle(EV_START);
    if (sample_valid) handle(EV_VALID);
    if (timeout_err)  handle(EV_TERR);
    x_prev   = x_axis_out;
    y_prev   = y_axis_out;
    rst_prev = rst;
  end

  // Bounded wait for an output pulse: 0 start, 1 valid, 2 timeout.
  task automatic wait_for(input int which);
    int n   = 0;
    bit hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = adc_start;
        1:       hit = sample_valid;
        default: hit = timeout_err;
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_event_%0d: got no pulse in %0d cycles, expected one within 100", which, n);
    end
  endtask

  // ADC model: called at the negedge where adc_start is seen, strobes done k cycles later.
  task automatic respond(input int k, input logic [9:0] d);
    repeat (k) @(posedge clk);
    #1 adc_done = 1'b1; adc_data = d;
    @(posedge clk);
    #1 adc_done = 1'b0; adc_data = '0;
  endtask

  initial begin
    int c0;
    int starts;
    rst = 1'b1; enable = 1'b0; adc_done = 1'b0; adc_data = '0;

    // Reset values after holding rst for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", 32'(x_axis_out), 32'd512);
    check("rst_y", 32'(y_axis_out), 32'd512);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_start", 32'(adc_start), 32'd0);
    check("rst_ch", 32'(adc_ch), 32'd6);

    // First round: X=100, Y=900, k=3 -> 8-cycle round.
    push(EV_START, 10'd6, 10'd0, -1);
    @(posedge clk); #1 rst = 1'b0; enable = 1'b1;
    c0 = cyc;
    wait_for(0);
    check("first_start_latency", 32'(cyc - c0), 32'd4);
    push(EV_START, 10'd7, 10'd0, 4);
    push(EV_VALID, 10'd100, 10'd900, 4);
    respond(3, 10'd100);
    wait_for(0);
    respond(3, 10'd900);
    wait_for(1);

    // Y never answers: timeout one cycle after the 5th wait cycle.
    @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; enable = 1'b1;
    push(EV_START, 10'd6, 10'd0, -1);
    wait_for(0);
    push(EV_START, 10'd7, 10'd0, 2);
    push(EV_TERR, 10'd0, 10'd0, TIMEOUT + 1);
    respond(1, 10'd50);
    wait_for(0);
    wait_for(2);
    // Next round: done arrives on the final timeout cycle of Y.
    push(EV_START, 10'd6, 10'd0, -1);
    push(EV_START, 10'd7, 10'd0, 3);
    push(EV_VALID, 10'd300, 10'd700, TIMEOUT + 1);
    adc_done = 1'b1; adc_data = 10'd77;
    @(negedge clk);
    adc_done = 1'b0; adc_data = '0;
    repeat (2) @(negedge clk);
    check("abort_keeps_x", 32'(x_axis_out), 32'd512);
    check("abort_keeps_y", 32'(y_axis_out), 32'd512);
    wait_for(0);
    respond(2, 10'd300);
    wait_for(0);
    respond(TIMEOUT, 10'd700);
    wait_for(1);

    // enable dropped during S_WAIT_X: round still commits.
    push(EV_START, 10'd6, 10'd0, -1);
    push(EV_START, 10'd7, 10'd0, 3);
    push(EV_VALID, 10'd222, 10'd333, 3);
    wait_for(0);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 adc_done = 1'b1; adc_data = 10'd222;
    @(posedge clk); #1 adc_done = 1'b0; adc_data = '0;
    wait_for(0);
    respond(2, 10'd333);
    wait_for(1);
    starts = 0;
    repeat (10) begin @(negedge clk); if (adc_start) starts++; end
    check("no_start_while_disabled", 32'(starts), 32'd0);
    // Two enabled cycles, a long disabled gap, then resume from count 2.
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    starts = 0;
    repeat (10) begin @(negedge clk); if (adc_start) starts++; end
    check("no_start_during_hold", 32'(starts), 32'd0);
    push(EV_START, 10'd6, 10'd0, -1);
    @(posedge clk); #1 enable = 1'b1;
    c0 = cyc;
    wait_for(0);
    check("period_resume", 32'(cyc - c0), 32'd2);

    // Reset during S_WAIT_Y; a following done is ignored.
    push(EV_START, 10'd7, 10'd0, 2);
    respond(1, 10'd10);
    wait_for(0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("midreset_x", 32'(x_axis_out), 32'd512);
    check("midreset_y", 32'(y_axis_out), 32'd512);
    check("midreset_start", 32'(adc_start), 32'd0);
    check("midreset_ch", 32'(adc_ch), 32'd6);
    adc_done = 1'b1; adc_data = 10'd999;
    @(negedge clk);
    adc_done = 1'b0; adc_data = '0;
    repeat (3) @(negedge clk);
    check("post_reset_done_x", 32'(x_axis_out), 32'd512);
    check("post_reset_done_y", 32'(y_axis_out), 32'd512);
    check("leftover_expected_events", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
